// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB slave memory model.
package apb_slave_pkg;
  localparam int NUM_SLAVES = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_MULTI_SEL = 2'd1,
    ERR_SEQ       = 2'd2,
    ERR_UNSTABLE  = 2'd3
  } err_t;

  function automatic logic is_onehot(input logic [NUM_SLAVES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/apb_slave_mem_if.sv
// APB request/response signals between the bridge (master) and the memory slave.
interface apb_slave_mem_if;
  import apb_slave_pkg::*;

  logic [NUM_SLAVES-1:0] Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [31:0]           Paddr;
  logic [31:0]           Pwdata;
  logic [31:0]           Prdata;

  modport master (output Pselx, output Penable, output Pwrite,
                  output Paddr, output Pwdata, input Prdata);
  modport slave  (input Pselx, input Penable, input Pwrite,
                  input Paddr, input Pwdata, output Prdata);
endinterface

// File: rtl/apb_slave_bank.sv
// One word-addressed memory bank: cleared by reset, one write port, combinational read.
module apb_slave_bank #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [31:0]              rdata
);
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = mem_q[ridx];
endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with four memory banks, phase tracking, protocol error capture and
// saturating transfer counters.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             Hclk,
  input  logic             Hreset,
  apb_slave_mem_if.slave   bus,
  output logic             err_flag,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count
);
  localparam int IW = $clog2(DEPTH);

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           prdata_q, prdata_d;
  logic                  err_flag_q, err_flag_d;
  err_t                  err_code_q, err_code_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;

  logic [IW-1:0]         idx_in;
  logic [NUM_SLAVES-1:0] bank_we;
  logic [31:0]           bank_rdata [NUM_SLAVES];
  logic [31:0]           sel_rdata;
  logic                  err_hit;
  err_t                  err_kind;
  logic                  idle_rules;
  logic                  mismatch;
  logic                  unused_paddr;

  assign idx_in       = bus.Paddr[2 +: IW];
  assign unused_paddr = ^{bus.Paddr[31:2+IW], bus.Paddr[1:0]};

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_bank
    apb_slave_bank #(.DEPTH(DEPTH)) u_bank (
      .clk   (Hclk),
      .srst  (Hreset),
      .we    (bank_we[gi]),
      .widx  (idx_q),
      .wdata (wdata_q),
      .ridx  (idx_in),
      .rdata (bank_rdata[gi])
    );
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (bus.Pselx[i]) sel_rdata = sel_rdata | bank_rdata[i];
    end
  end

  assign mismatch = (idx_in != idx_q) || (bus.Pwrite != wr_q) ||
                    (wr_q && (bus.Pwdata != wdata_q));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    prdata_d   = prdata_q;
    err_flag_d = err_flag_q;
    err_code_d = err_code_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    bank_we    = '0;
    err_hit    = 1'b0;
    err_kind   = ERR_NONE;
    idle_rules = 1'b0;

    case (state_q)
      SETUP: begin
        if (bus.Penable && (bus.Pselx == sel_q)) begin
          state_d = ACCESS;
          if (mismatch) begin
            err_hit  = 1'b1;
            err_kind = ERR_UNSTABLE;
          end else if (wr_q) begin
            bank_we = sel_q;
            if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
          end else begin
            if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end else begin
          // A broken setup is flagged, but the same inputs may still start a new transfer.
          err_hit    = 1'b1;
          err_kind   = ERR_SEQ;
          idle_rules = 1'b1;
        end
      end
      default: idle_rules = 1'b1;
    endcase

    if (idle_rules) begin
      if (bus.Penable) begin
        if (!err_hit) err_kind = ERR_SEQ;
        err_hit = 1'b1;
        state_d = IDLE;
      end else if (bus.Pselx == '0) begin
        state_d = IDLE;
      end else if (is_onehot(bus.Pselx)) begin
        state_d = SETUP;
        sel_d   = bus.Pselx;
        idx_d   = idx_in;
        wr_d    = bus.Pwrite;
        wdata_d = bus.Pwdata;
        if (!bus.Pwrite) prdata_d = sel_rdata;
      end else begin
        if (!err_hit) err_kind = ERR_MULTI_SEL;
        err_hit = 1'b1;
        state_d = IDLE;
      end
    end

    // Only the first error after reset is recorded in the code.
    if (err_hit) begin
      err_flag_d = 1'b1;
      if (!err_flag_q) err_code_d = err_kind;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      prdata_q   <= '0;
      err_flag_q <= 1'b0;
      err_code_q <= ERR_NONE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      prdata_q   <= prdata_d;
      err_flag_q <= err_flag_d;
      err_code_q <= err_code_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  assign bus.Prdata = prdata_q;
  assign err_flag   = err_flag_q;
  assign err_code   = err_code_q;
  assign wr_count   = wr_cnt_q;
  assign rd_count   = rd_cnt_q;
endmodule
